// File: rtl/result_reader_pkg.sv
// Shared definitions for the result buffer drain path: FSM encoding and
// the default address/data widths used by the accelerator result memory.
package result_reader_pkg;

    localparam int RR_DATA_WIDTH = 8;
    localparam int RR_ADDR_WIDTH = 8;

    // Drain controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_FINISH = 2'd2
    } rr_state_t;

endpackage

// File: rtl/result_reader_fifo.sv
// Two-entry synchronous FIFO that absorbs returning read data so that the
// host can stall without losing words. Flush clears pointers and storage.
module result_fifo #(
    parameter int W = 9
) (
    input  logic         i_clk,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_occ,
    output logic         o_empty
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_occ;

    // Storage, pointers and occupancy; push and pop may happen together.
    always_ff @(posedge i_clk) begin
        if (i_flush) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_occ   = r_occ;
    assign o_empty = (r_occ == 2'd0);

endmodule

// File: rtl/result_reader.sv
// Drains the accelerator result buffer after a run completes: detects the
// rising edge of finished, reads result_word_count words starting at
// result_base_address and streams them to the host.
//
// Output handshake: a word transfers in any cycle where out_valid and
// out_ready are both high. out_valid comes straight from FIFO occupancy and
// never looks at out_ready; once raised, out_valid/out_data/out_last hold
// until the transfer happens.
module result_reader
    import result_reader_pkg::*;
#(
    parameter int DATA_WIDTH = RR_DATA_WIDTH,
    parameter int ADDR_WIDTH = RR_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  finished,
    input  logic [ADDR_WIDTH-1:0] result_base_address,
    input  logic [ADDR_WIDTH-1:0] result_word_count,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    rr_state_t             r_state;
    rr_state_t             w_state_next;
    logic                  r_finished_q;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [ADDR_WIDTH-1:0] r_issued;
    logic                  r_inflight;
    logic                  r_inflight_last;

    logic                  w_trigger;
    logic                  w_issue;
    logic                  w_issue_last;
    logic                  w_pop;
    logic [2:0]            w_used;
    logic [1:0]            w_occ;
    logic                  w_empty;
    logic [DATA_WIDTH:0]   w_head;
    logic                  w_head_last;

    // Only a fresh rising edge seen while idle starts a drain.
    assign w_trigger = (r_state == ST_IDLE) && finished && !r_finished_q;

    assign w_pop       = !w_empty && out_ready;
    assign w_head_last = w_head[DATA_WIDTH];

    // Credits: words already buffered plus the one in flight, minus the one
    // leaving this cycle, must leave room in the 2-entry FIFO.
    assign w_used       = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue      = (r_state == ST_DRAIN) && (r_issued < r_count) && (w_used < 3'd2);
    assign w_issue_last = (r_issued == (r_count - ADDR_WIDTH'(1)));

    // State register, edge-detect history, drain bookkeeping and the
    // in-flight read tag that lines up with mem_data one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_finished_q    <= 1'b0;
            r_base          <= '0;
            r_count         <= '0;
            r_issued        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_finished_q    <= finished;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_issue_last;
            if (w_trigger) begin
                r_base   <= result_base_address;
                r_count  <= result_word_count;
                r_issued <= '0;
            end else if (w_issue) begin
                r_issued <= r_issued + ADDR_WIDTH'(1);
            end
        end
    end

    // Next-state: leave DRAIN when the final word is accepted by the host.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_trigger) begin
                    w_state_next = (result_word_count == '0) ? ST_FINISH : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pop && w_head_last) begin
                    w_state_next = ST_FINISH;
                end
            end
            ST_FINISH: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    result_fifo #(
        .W (DATA_WIDTH + 1)
    ) u_fifo (
        .i_clk   (clk),
        .i_flush (reset),
        .i_push  (r_inflight),
        .i_data  ({r_inflight_last, mem_data}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_occ   (w_occ),
        .o_empty (w_empty)
    );

    assign mem_rd_en = w_issue;
    assign mem_addr  = w_issue ? (r_base + r_issued) : '0;
    assign out_valid = !w_empty;
    assign out_data  = w_head[DATA_WIDTH-1:0];
    assign out_last  = !w_empty && w_head_last;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_FINISH);

endmodule

// File: doc/result_reader.md
# result_reader

Drains the result buffer of `NeuralAccelerator` once a run completes. It detects the rising edge of `finished` and latches `result_base_address` and `result_word_count`. It then reads that many words from the result memory's synchronous read port and streams them to the host over a valid/ready interface, asserting `last` on the final word and pulsing `done` when the drain is complete. It sits between the accelerator's result interface and the host/readout path, on the accelerator's clock.

## Interface
- `DATA_WIDTH`, default 8: result word width.
- `ADDR_WIDTH`, default 8: result memory address width; also the width of the word count.

Ports: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `finished`  in  1  accelerator run complete; level, held high after completion.
- `result_base_address`  in  ADDR_WIDTH  first result word address.
- `result_word_count`  in  ADDR_WIDTH  number of result words; 0 is legal.
- `mem_rd_en`  out  1  read strobe to result memory.
- `mem_addr`  out  ADDR_WIDTH  read address; valid when `mem_rd_en`=1.
- `mem_data`  in  DATA_WIDTH  read data; valid exactly 1 cycle after `mem_rd_en` (the accelerator's `data_out`).
- `out_valid`  out  1  output word available.
- `out_ready`  in  1  host accepts the word.
- `out_data`  out  DATA_WIDTH  output word.
- `out_last`  out  1  qualifies the final word of a drain.
- `busy`  out  1  a drain is in progress.
- `done`  out  1  one-cycle pulse at drain completion.

## Operation
- States: IDLE, DRAIN, FINISH.
- Trigger: `finished`=1 while the registered previous `finished`=0, in IDLE. At that edge the block latches base and count, clears the issue index, and enters DRAIN (count≠0) or FINISH (count=0).
- Edges of `finished` outside IDLE are ignored. A level held high never re-triggers.
- DRAIN issue rule: assert `mem_rd_en` with `mem_addr`=base+issued (mod 2^ADDR_WIDTH) when issued<count and fifo_occupancy + inflight − pop_this_cycle < 2.
- Returning `mem_data` is pushed into a 2-entry FIFO one cycle after issue. `out_valid`=FIFO not empty; `out_data`=FIFO head.
- `out_last`=1 on the head word when it is the count-th word of the drain.
- A handshake (`out_valid`&&`out_ready`) pops the FIFO.
- DRAIN→FINISH at the handshake of the last word. FINISH lasts one cycle, asserts `done`=1, then returns to IDLE.
- `busy`=1 in DRAIN and FINISH.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. The word counter is ADDR_WIDTH bits wide, so the maximum count is 2^ADDR_WIDTH−1.
- Reset mid-operation: state→IDLE, FIFO flushed, in-flight read discarded, previous-`finished` register cleared. If `finished` is still high after reset, a new drain is triggered.

## Timing
- Reset values: `mem_rd_en`=0, `mem_addr`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0.
- Trigger detected in cycle T: first `mem_rd_en` in T+1, first `out_valid` in T+3.
- With `out_ready` held high: one word per cycle; last word in T+2+count, `done` in T+3+count.
- Count 0: `done` in T+1; no reads and no output words.
- `out_valid`, `out_data` and `out_last` hold stable while `out_valid`=1 and `out_ready`=0.
- The FIFO never overflows under any `out_ready` pattern.
- `out_valid` must not depend combinationally on `out_ready`.

## Structure
- Shared package `result_reader_pkg`: state encoding (IDLE, DRAIN, FINISH) and default widths DATA_WIDTH=8 and ADDR_WIDTH=8, shared with the accelerator's address/data width constants.
- Sub-module `result_fifo`: 2-entry synchronous FIFO with push, pop, head, occupancy and a synchronous flush on reset.
- Everything else (FSM, edge detect, issue/credit logic, counters) lives in `result_reader`.

## Test plan
- Base 0x10, count 3, memory[0x10..0x12]=A1,B2,C3, `out_ready`=1 → reads at 0x10–0x12 in T+1..T+3. Words A1,B2,C3 in T+3..T+5 with `out_last` on C3; `done` in T+6.
- Same setup, `out_ready` toggling 1,0,0,1,… → same word order; data held stable while stalled. `mem_rd_en` never creates more than 2 outstanding words.
- Count 0 → no `mem_rd_en`, no `out_valid`; `done` in T+1; `busy` high for 1 cycle.
- Base 0xFE, count 4 → addresses 0xFE, 0xFF, 0x00, 0x01; 4 words, `out_last` on the 4th.
- `reset` asserted after 2 of 5 words, with `finished` held high → outputs return to reset values the next cycle. A fresh drain then starts from the base address with the first word at the base address.
- `finished` held high after a completed drain → no second drain. Drop `finished` low then raise it again → exactly one new drain.
